// File: rtl/k_means_cnfg_master.sv
// AXI4-Lite master that writes a k-means job descriptor into the operator's
// configuration slave, starts it through CTRL, then polls STAT until done.
module k_means_cnfg_master #(
   parameter int unsigned AXIL_DATA_BITS   = 64,
   parameter int unsigned AXIL_ADDR_BITS   = 32,
   parameter int unsigned NUM_CLUSTER_BITS = 8,
   parameter int unsigned MAX_DEPTH_BITS   = 16,
   parameter int unsigned POLL_GAP         = 16,
   parameter logic [31:0] MAX_POLLS        = 32'd1048576,
   parameter logic [AXIL_ADDR_BITS-1:0] BASE_ADDR = '0
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   // AXI4-Lite master port to the operator configuration slave
   output logic                          axi_ctrl_awvalid,
   input  logic                          axi_ctrl_awready,
   output logic [AXIL_ADDR_BITS-1:0]     axi_ctrl_awaddr,
   output logic [2:0]                    axi_ctrl_awprot,
   output logic                          axi_ctrl_wvalid,
   input  logic                          axi_ctrl_wready,
   output logic [AXIL_DATA_BITS-1:0]     axi_ctrl_wdata,
   output logic [AXIL_DATA_BITS/8-1:0]   axi_ctrl_wstrb,
   input  logic                          axi_ctrl_bvalid,
   output logic                          axi_ctrl_bready,
   input  logic [1:0]                    axi_ctrl_bresp,
   output logic                          axi_ctrl_arvalid,
   input  logic                          axi_ctrl_arready,
   output logic [AXIL_ADDR_BITS-1:0]     axi_ctrl_araddr,
   output logic [2:0]                    axi_ctrl_arprot,
   input  logic                          axi_ctrl_rvalid,
   output logic                          axi_ctrl_rready,
   input  logic [AXIL_DATA_BITS-1:0]     axi_ctrl_rdata,
   input  logic [1:0]                    axi_ctrl_rresp,
   // job descriptor interface
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [NUM_CLUSTER_BITS:0]     cmd_num_clusters,
   input  logic [MAX_DEPTH_BITS:0]       cmd_data_dim,
   input  logic [63:0]                   cmd_data_set_size,
   input  logic [7:0]                    cmd_precision,
   input  logic                          cmd_select,
   // status
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [1:0]                    err_code
);

   localparam int unsigned STRB_BITS = AXIL_DATA_BITS / 8;
   localparam int unsigned STRIDE    = AXIL_DATA_BITS / 8;
   localparam logic [2:0]  IDX_STAT  = 3'd1;
   localparam logic [2:0]  SEQ_LAST  = 3'd5;
   localparam logic [31:0] GAP_LAST  = 32'(POLL_GAP - 1);

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_RESP, POLL_RD, POLL_DATA, POLL_WAIT, FIN, ERR
   } state_t;

   state_t                        state_q, state_d;
   logic [2:0]                    seq_q, seq_d;
   logic [31:0]                   poll_q, poll_d;
   logic [31:0]                   gap_q, gap_d;
   logic                          sel_q, sel_d;
   logic [NUM_CLUSTER_BITS:0]     ncl_q, ncl_d;
   logic [MAX_DEPTH_BITS:0]       dim_q, dim_d;
   logic [7:0]                    prec_q, prec_d;
   logic [63:0]                   size_q, size_d;
   logic                          cmd_ready_d, busy_d, done_d, error_d;
   logic [1:0]                    err_code_d;
   logic                          awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
   logic [AXIL_ADDR_BITS-1:0]     awaddr_d, araddr_d;
   logic [AXIL_DATA_BITS-1:0]     wdata_d;
   logic [STRB_BITS-1:0]          wstrb_d;
   logic                          unused_rdata;

   assign axi_ctrl_awprot = 3'b000;
   assign axi_ctrl_arprot = 3'b000;
   assign unused_rdata    = ^axi_ctrl_rdata[AXIL_DATA_BITS-1:1];

   // Register index written at each step: SELECT, NUM_CLUSTERS, DATA_DIM, PRECISION, DATA_SET_SIZE, CTRL
   function automatic logic [2:0] seq_reg(input logic [2:0] s);
      unique case (s)
         3'd0:    return 3'd2;
         3'd1:    return 3'd3;
         3'd2:    return 3'd4;
         3'd3:    return 3'd5;
         3'd4:    return 3'd6;
         default: return 3'd0;
      endcase
   endfunction

   // Byte address of a register index
   function automatic logic [AXIL_ADDR_BITS-1:0] reg_addr(input logic [2:0] idx);
      return BASE_ADDR + AXIL_ADDR_BITS'(idx) * AXIL_ADDR_BITS'(STRIDE);
   endfunction

   // Zero-extended write payload for each step; the last step starts the operator
   function automatic logic [AXIL_DATA_BITS-1:0] seq_data(
      input logic [2:0]              s,
      input logic                    sel,
      input logic [NUM_CLUSTER_BITS:0] ncl,
      input logic [MAX_DEPTH_BITS:0] dim,
      input logic [7:0]              prec,
      input logic [63:0]             size);
      unique case (s)
         3'd0:    return AXIL_DATA_BITS'(sel);
         3'd1:    return AXIL_DATA_BITS'(ncl);
         3'd2:    return AXIL_DATA_BITS'(dim);
         3'd3:    return AXIL_DATA_BITS'(prec);
         3'd4:    return AXIL_DATA_BITS'(size);
         default: return AXIL_DATA_BITS'(1);
      endcase
   endfunction

   // State register and registered outputs
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q          <= IDLE;
         seq_q            <= '0;
         poll_q           <= '0;
         gap_q            <= '0;
         sel_q            <= 1'b0;
         ncl_q            <= '0;
         dim_q            <= '0;
         prec_q           <= '0;
         size_q           <= '0;
         cmd_ready        <= 1'b0;
         busy             <= 1'b0;
         done             <= 1'b0;
         error            <= 1'b0;
         err_code         <= 2'd0;
         axi_ctrl_awvalid <= 1'b0;
         axi_ctrl_awaddr  <= '0;
         axi_ctrl_wvalid  <= 1'b0;
         axi_ctrl_wdata   <= '0;
         axi_ctrl_wstrb   <= '0;
         axi_ctrl_bready  <= 1'b0;
         axi_ctrl_arvalid <= 1'b0;
         axi_ctrl_araddr  <= '0;
         axi_ctrl_rready  <= 1'b0;
      end else begin
         state_q          <= state_d;
         seq_q            <= seq_d;
         poll_q           <= poll_d;
         gap_q            <= gap_d;
         sel_q            <= sel_d;
         ncl_q            <= ncl_d;
         dim_q            <= dim_d;
         prec_q           <= prec_d;
         size_q           <= size_d;
         cmd_ready        <= cmd_ready_d;
         busy             <= busy_d;
         done             <= done_d;
         error            <= error_d;
         err_code         <= err_code_d;
         axi_ctrl_awvalid <= awvalid_d;
         axi_ctrl_awaddr  <= awaddr_d;
         axi_ctrl_wvalid  <= wvalid_d;
         axi_ctrl_wdata   <= wdata_d;
         axi_ctrl_wstrb   <= wstrb_d;
         axi_ctrl_bready  <= bready_d;
         axi_ctrl_arvalid <= arvalid_d;
         axi_ctrl_araddr  <= araddr_d;
         axi_ctrl_rready  <= rready_d;
      end
   end

   // Next-state and next-output logic; outputs hold unless a transition changes them
   always_comb begin
      state_d     = state_q;
      seq_d       = seq_q;
      poll_d      = poll_q;
      gap_d       = gap_q;
      sel_d       = sel_q;
      ncl_d       = ncl_q;
      dim_d       = dim_q;
      prec_d      = prec_q;
      size_d      = size_q;
      cmd_ready_d = cmd_ready;
      busy_d      = busy;
      done_d      = 1'b0;
      error_d     = error;
      err_code_d  = err_code;
      awvalid_d   = axi_ctrl_awvalid;
      awaddr_d    = axi_ctrl_awaddr;
      wvalid_d    = axi_ctrl_wvalid;
      wdata_d     = axi_ctrl_wdata;
      wstrb_d     = axi_ctrl_wstrb;
      bready_d    = axi_ctrl_bready;
      arvalid_d   = axi_ctrl_arvalid;
      araddr_d    = axi_ctrl_araddr;
      rready_d    = axi_ctrl_rready;

      unique case (state_q)
         IDLE: begin
            cmd_ready_d = 1'b1;
            if (cmd_valid && cmd_ready) begin
               sel_d       = cmd_select;
               ncl_d       = cmd_num_clusters;
               dim_d       = cmd_data_dim;
               prec_d      = cmd_precision;
               size_d      = cmd_data_set_size;
               cmd_ready_d = 1'b0;
               busy_d      = 1'b1;
               error_d     = 1'b0;
               err_code_d  = 2'd0;
               seq_d       = 3'd0;
               awvalid_d   = 1'b1;
               awaddr_d    = reg_addr(seq_reg(3'd0));
               wvalid_d    = 1'b1;
               wdata_d     = seq_data(3'd0, cmd_select, cmd_num_clusters, cmd_data_dim,
                                      cmd_precision, cmd_data_set_size);
               wstrb_d     = '1;
               state_d     = WR_ADDR;
            end
         end
         WR_ADDR: begin
            if (axi_ctrl_awvalid && axi_ctrl_awready) awvalid_d = 1'b0;
            if (axi_ctrl_wvalid && axi_ctrl_wready)   wvalid_d  = 1'b0;
            // a dropped valid means that channel already handshook
            if ((!axi_ctrl_awvalid || axi_ctrl_awready) && (!axi_ctrl_wvalid || axi_ctrl_wready)) begin
               bready_d = 1'b1;
               state_d  = WR_RESP;
            end
         end
         WR_RESP: begin
            if (axi_ctrl_bvalid && axi_ctrl_bready) begin
               bready_d = 1'b0;
               if (axi_ctrl_bresp != 2'b00) begin
                  err_code_d = 2'd1;
                  error_d    = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = ERR;
               end else if (seq_q == SEQ_LAST) begin
                  poll_d    = '0;
                  arvalid_d = 1'b1;
                  araddr_d  = reg_addr(IDX_STAT);
                  state_d   = POLL_RD;
               end else begin
                  seq_d     = seq_q + 3'd1;
                  awvalid_d = 1'b1;
                  awaddr_d  = reg_addr(seq_reg(seq_q + 3'd1));
                  wvalid_d  = 1'b1;
                  wdata_d   = seq_data(seq_q + 3'd1, sel_q, ncl_q, dim_q, prec_q, size_q);
                  state_d   = WR_ADDR;
               end
            end
         end
         POLL_RD: begin
            if (axi_ctrl_arvalid && axi_ctrl_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = POLL_DATA;
            end
         end
         POLL_DATA: begin
            if (axi_ctrl_rvalid && axi_ctrl_rready) begin
               rready_d = 1'b0;
               if (axi_ctrl_rresp != 2'b00) begin
                  err_code_d = 2'd2;
                  error_d    = 1'b1;
                  busy_d     = 1'b0;
                  state_d    = ERR;
               end else if (axi_ctrl_rdata[0]) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = FIN;
               end else begin
                  poll_d = poll_q + 32'd1;
                  if ((MAX_POLLS != 32'd0) && (poll_q + 32'd1 == MAX_POLLS)) begin
                     err_code_d = 2'd3;
                     error_d    = 1'b1;
                     busy_d     = 1'b0;
                     state_d    = ERR;
                  end else if (POLL_GAP == 0) begin
                     arvalid_d = 1'b1;
                     state_d   = POLL_RD;
                  end else begin
                     gap_d   = '0;
                     state_d = POLL_WAIT;
                  end
               end
            end
         end
         POLL_WAIT: begin
            if (gap_q == GAP_LAST) begin
               arvalid_d = 1'b1;
               state_d   = POLL_RD;
            end else begin
               gap_d = gap_q + 32'd1;
            end
         end
         FIN: begin
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
         end
         ERR: begin
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_k_means_cnfg_master.sv
// Scoreboard bench: directed jobs push expected AXI events, a monitor pops and compares.
module tb_k_means_cnfg_master;

   localparam int unsigned DW  = 64;
   localparam int unsigned AW  = 32;
   localparam int unsigned NCB = 8;
   localparam int unsigned MDB = 16;
   localparam int unsigned GAP = 3;
   localparam int EV_WR = 0, EV_RD = 1, EV_DONE = 2, EV_ERR = 3;

   typedef struct {
      int          kind;
      logic [31:0] addr;
      logic [63:0] data;
   } ev_t;

   logic clk, aresetn;
   logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
   logic [AW-1:0] awaddr, araddr;
   logic [2:0]    awprot, arprot;
   logic [DW-1:0] wdata, rdata;
   logic [7:0]    wstrb;
   logic [1:0]    bresp, rresp;
   logic          cmd_valid, cmd_ready, cmd_select, busy, done, error;
   logic [NCB:0]  cmd_num_clusters;
   logic [MDB:0]  cmd_data_dim;
   logic [63:0]   cmd_data_set_size;
   logic [7:0]    cmd_precision;
   logic [1:0]    err_code;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   // slave model configuration (written by the stimulus process only)
   int aw_lag = 0, w_lag = 0, bad_b_idx = -1, done_on_poll = 1, bad_r_poll = 0;
   // slave model state
   int aw_cnt = 0, w_cnt = 0, wr_idx = 0, poll_n = 0;
   bit aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0, aw_got = 0, w_got = 0;
   // monitor state
   logic [31:0] m_addr, m_prev_awaddr;
   logic [63:0] m_data, m_prev_wdata;
   bit m_aw_have = 0, m_w_have = 0, m_lat = 0, m_armed = 0, m_prev_err = 0, m_aw_wait = 0, m_w_wait = 0;
   int m_gap = 0;

   k_means_cnfg_master #(
      .AXIL_DATA_BITS(DW), .AXIL_ADDR_BITS(AW), .NUM_CLUSTER_BITS(NCB), .MAX_DEPTH_BITS(MDB),
      .POLL_GAP(GAP), .MAX_POLLS(32'd4), .BASE_ADDR(32'd0)
   ) dut (
      .aclk(clk), .aresetn(aresetn),
      .axi_ctrl_awvalid(awvalid), .axi_ctrl_awready(awready), .axi_ctrl_awaddr(awaddr),
      .axi_ctrl_awprot(awprot), .axi_ctrl_wvalid(wvalid), .axi_ctrl_wready(wready),
      .axi_ctrl_wdata(wdata), .axi_ctrl_wstrb(wstrb), .axi_ctrl_bvalid(bvalid),
      .axi_ctrl_bready(bready), .axi_ctrl_bresp(bresp), .axi_ctrl_arvalid(arvalid),
      .axi_ctrl_arready(arready), .axi_ctrl_araddr(araddr), .axi_ctrl_arprot(arprot),
      .axi_ctrl_rvalid(rvalid), .axi_ctrl_rready(rready), .axi_ctrl_rdata(rdata),
      .axi_ctrl_rresp(rresp),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_num_clusters(cmd_num_clusters),
      .cmd_data_dim(cmd_data_dim), .cmd_data_set_size(cmd_data_set_size),
      .cmd_precision(cmd_precision), .cmd_select(cmd_select),
      .busy(busy), .done(done), .error(error), .err_code(err_code)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, %0d events still expected", exp_q.size());
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_ev(input int kind, input logic [31:0] a, input logic [63:0] d);
      ev_t e;
      e.kind = kind; e.addr = a; e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic push_writes(input int n, input logic [63:0] sel, input logic [63:0] ncl,
                              input logic [63:0] dim, input logic [63:0] prec, input logic [63:0] size);
      if (n > 0) push_ev(EV_WR, 32'h10, sel);
      if (n > 1) push_ev(EV_WR, 32'h18, ncl);
      if (n > 2) push_ev(EV_WR, 32'h20, dim);
      if (n > 3) push_ev(EV_WR, 32'h28, prec);
      if (n > 4) push_ev(EV_WR, 32'h30, size);
      if (n > 5) push_ev(EV_WR, 32'h00, 64'd1);
   endtask

   task automatic push_reads(input int n);
      for (int i = 0; i < n; i++) push_ev(EV_RD, 32'h08, 64'd0);
   endtask

   task automatic got_ev(input int kind, input logic [31:0] a, input logic [63:0] d, input string name);
      ev_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_%s: got addr %h data %h expected no event", name, a, d);
      end else begin
         e = exp_q.pop_front();
         chk({name, "_kind"}, 64'(kind), 64'(e.kind));
         chk({name, "_addr"}, 64'(a), 64'(e.addr));
         chk({name, "_data"}, d, e.data);
      end
   endtask

   task automatic issue(input logic sel, input logic [NCB:0] ncl, input logic [MDB:0] dim,
                        input logic [7:0] prec, input logic [63:0] size);
      int n = 0;
      @(negedge clk);
      cmd_select = sel; cmd_num_clusters = ncl; cmd_data_dim = dim;
      cmd_precision = prec; cmd_data_set_size = size; cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_accept", 64'(cmd_ready), 64'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_quiet(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || !cmd_ready) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_pending_events"}, 64'(exp_q.size()), 64'd0);
      repeat (10) @(negedge clk);
   endtask

   task automatic slave_cfg(input int al, input int wl, input int bb, input int dp, input int br);
      aw_lag = al; w_lag = wl; bad_b_idx = bb; done_on_poll = dp; bad_r_poll = br;
   endtask

   // AXI4-Lite slave model: updates on the falling edge, counters restart whenever the master is idle
   initial begin
      awready = 0; wready = 0; bvalid = 0; bresp = 0; arready = 0; rvalid = 0; rresp = 0; rdata = 0;
      forever begin
         @(negedge clk);
         if (!aresetn) begin
            awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
            aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
            aw_got = 0; w_got = 0; aw_cnt = 0; w_cnt = 0; wr_idx = 0; poll_n = 0;
         end else begin
            if (!busy) begin wr_idx = 0; poll_n = 0; end
            if (aw_fire) begin awready = 0; aw_fire = 0; aw_got = 1; aw_cnt = 0; end
            else if (awvalid && !awready) begin
               if (aw_cnt >= aw_lag) awready = 1; else aw_cnt++;
            end
            if (awready && awvalid) aw_fire = 1;
            if (w_fire) begin wready = 0; w_fire = 0; w_got = 1; w_cnt = 0; end
            else if (wvalid && !wready) begin
               if (w_cnt >= w_lag) wready = 1; else w_cnt++;
            end
            if (wready && wvalid) w_fire = 1;
            if (b_fire) begin bvalid = 0; b_fire = 0; end
            else if (aw_got && w_got && !bvalid) begin
               bvalid = 1;
               bresp  = (wr_idx == bad_b_idx) ? 2'd2 : 2'd0;
               wr_idx++;
               aw_got = 0; w_got = 0;
            end
            if (bvalid && bready) b_fire = 1;
            if (r_fire) begin rvalid = 0; r_fire = 0; end
            if (ar_fire) begin
               arready = 0; ar_fire = 0; poll_n++;
               rvalid = 1;
               rdata  = 64'hA5A5_0000_0000_0000 | ((poll_n == done_on_poll) ? 64'd1 : 64'd0);
               rresp  = (poll_n == bad_r_poll) ? 2'd2 : 2'd0;
            end else if (arvalid && !arready) arready = 1;
            if (arready && arvalid) ar_fire = 1;
            if (rvalid && rready) r_fire = 1;
         end
      end
   end

   // Monitor: samples just after the falling edge, i.e. the values the next rising edge will see
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!aresetn) begin
            m_aw_have = 0; m_w_have = 0; m_lat = 0; m_armed = 0;
            m_prev_err = 0; m_aw_wait = 0; m_w_wait = 0;
         end else begin
            if (m_aw_wait) begin
               chk("aw_hold_valid", 64'(awvalid), 64'd1);
               chk("aw_hold_addr", 64'(awaddr), 64'(m_prev_awaddr));
            end
            if (m_w_wait) begin
               chk("w_hold_valid", 64'(wvalid), 64'd1);
               chk("w_hold_data", wdata, m_prev_wdata);
            end
            m_aw_wait = awvalid && !awready; m_prev_awaddr = awaddr;
            m_w_wait  = wvalid && !wready;   m_prev_wdata  = wdata;
            if (awvalid && awready) begin m_addr = awaddr; m_aw_have = 1; end
            if (wvalid && wready) begin
               m_data = wdata;
               chk("wstrb", 64'(wstrb), 64'hFF);
               m_w_have = 1;
            end
            if (m_aw_have && m_w_have) begin
               got_ev(EV_WR, m_addr, m_data, "write");
               m_aw_have = 0; m_w_have = 0;
            end
            if (arvalid && arready) got_ev(EV_RD, araddr, 64'd0, "stat_read");
            if (m_lat) begin
               chk("first_awvalid_latency", 64'(awvalid), 64'd1);
               chk("cmd_ready_low_after_accept", 64'(cmd_ready), 64'd0);
               chk("busy_after_accept", 64'(busy), 64'd1);
               chk("error_cleared_on_accept", {62'd0, error, 1'b0} | 64'(err_code), 64'd0);
               m_lat = 0;
            end
            if (cmd_valid && cmd_ready) begin m_lat = 1; m_armed = 0; end
            if (rvalid && rready) begin m_armed = 1; m_gap = 0; end
            else if (m_armed) begin
               if (arvalid) begin
                  chk("poll_gap", 64'(m_gap), 64'(GAP));
                  m_armed = 0;
               end else m_gap++;
            end
            if (done) got_ev(EV_DONE, 32'd0, 64'(error), "done");
            if (error && !m_prev_err) got_ev(EV_ERR, 32'd0, 64'(err_code), "error");
            m_prev_err = error;
         end
      end
   end

   // Directed stimulus
   initial begin
      int n;
      aresetn = 1'b1; cmd_valid = 1'b0; cmd_select = 1'b0; cmd_num_clusters = '0;
      cmd_data_dim = '0; cmd_precision = '0; cmd_data_set_size = '0;
      #1 aresetn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
      chk("rst_status", {60'd0, busy, done, error, 1'b0} | 64'(err_code), 64'd0);
      chk("rst_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
      chk("rst_awaddr_araddr", {awaddr, araddr}, 64'd0);
      chk("rst_wdata", wdata, 64'd0);
      chk("rst_wstrb_prot", 64'({wstrb, awprot, arprot}), 64'd0);
      #1 aresetn = 1'b1;

      // nominal job: done on the third STAT read
      slave_cfg(0, 0, -1, 3, 0);
      push_writes(6, 64'd1, 64'd8, 64'd16, 64'd32, 64'h1_0000_0000);
      push_reads(3);
      push_ev(EV_DONE, 32'd0, 64'd0);
      issue(1'b1, 9'd8, 17'd16, 8'd32, 64'h1_0000_0000);
      wait_quiet("nominal");
      chk("nominal_status", {61'd0, busy, error, 1'b0} | 64'(err_code), 64'd0);

      // W accepted four cycles after AW
      slave_cfg(0, 4, -1, 1, 0);
      push_writes(6, 64'd0, 64'd3, 64'd5, 64'd16, 64'h1234);
      push_reads(1);
      push_ev(EV_DONE, 32'd0, 64'd0);
      issue(1'b0, 9'd3, 17'd5, 8'd16, 64'h1234);
      wait_quiet("skew_w_late");

      // AW accepted four cycles after W, maximum field values
      slave_cfg(4, 0, -1, 1, 0);
      push_writes(6, 64'd1, 64'h1FF, 64'h1FFFF, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      push_reads(1);
      push_ev(EV_DONE, 32'd0, 64'd0);
      issue(1'b1, 9'h1FF, 17'h1FFFF, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_quiet("skew_aw_late");

      // bad write response on DATA_DIM
      slave_cfg(0, 0, 2, 1, 0);
      push_writes(3, 64'd0, 64'd4, 64'd7, 64'd0, 64'd0);
      push_ev(EV_ERR, 32'd0, 64'd1);
      issue(1'b0, 9'd4, 17'd7, 8'd8, 64'd99);
      wait_quiet("bresp_err");
      chk("bresp_err_state", 64'({cmd_ready, busy, done, error, err_code}), 64'b1_0_0_1_01);

      // STAT never completes: four reads then timeout
      slave_cfg(0, 0, -1, 0, 0);
      push_writes(6, 64'd1, 64'd2, 64'd3, 64'd4, 64'd5);
      push_reads(4);
      push_ev(EV_ERR, 32'd0, 64'd3);
      issue(1'b1, 9'd2, 17'd3, 8'd4, 64'd5);
      wait_quiet("timeout");
      chk("timeout_state", 64'({busy, error, err_code}), 64'b0_1_11);

      // a good job after the timeout clears the error
      slave_cfg(0, 0, -1, 2, 0);
      push_writes(6, 64'd0, 64'd6, 64'd12, 64'd64, 64'h8000_0000);
      push_reads(2);
      push_ev(EV_DONE, 32'd0, 64'd0);
      issue(1'b0, 9'd6, 17'd12, 8'd64, 64'h8000_0000);
      wait_quiet("recover");
      chk("recover_state", 64'({error, err_code}), 64'd0);

      // bad read response on the second STAT read
      slave_cfg(0, 0, -1, 0, 2);
      push_writes(6, 64'd1, 64'd1, 64'd1, 64'd1, 64'd1);
      push_reads(2);
      push_ev(EV_ERR, 32'd0, 64'd2);
      issue(1'b1, 9'd1, 17'd1, 8'd1, 64'd1);
      wait_quiet("rresp_err");
      chk("rresp_err_code", 64'(err_code), 64'd2);

      // reset while a write address is outstanding
      slave_cfg(2, 2, -1, 1, 0);
      push_writes(6, 64'd1, 64'd8, 64'd16, 64'd32, 64'd48);
      issue(1'b1, 9'd8, 17'd16, 8'd32, 64'd48);
      n = 0;
      while (!(wr_idx >= 2 && awvalid) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("mid_reset_reached_write", 64'(awvalid), 64'd1);
      @(posedge clk);
      #3 aresetn = 1'b0;
      #1;
      chk("mid_reset_valids", 64'({awvalid, wvalid, bready, arvalid, rready}), 64'd0);
      chk("mid_reset_status", 64'({cmd_ready, busy, done, error}), 64'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #2 aresetn = 1'b1;
      n = 0;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("post_reset_idle", 64'({cmd_ready, busy, error}), 64'b100);

      // clean job after the reset
      slave_cfg(1, 1, -1, 3, 0);
      push_writes(6, 64'd0, 64'd10, 64'd20, 64'd30, 64'd40);
      push_reads(3);
      push_ev(EV_DONE, 32'd0, 64'd0);
      issue(1'b0, 9'd10, 17'd20, 8'd30, 64'd40);
      wait_quiet("after_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/k_means_cnfg_master.md
Name: k_means_cnfg_master

Overview:
AXI4-Lite master that programs and runs the k-means operator's configuration slave over its AXI4L control port. It accepts one job descriptor per handshake, writes the parameter registers, then writes CTRL to start the operator. It then polls STAT until the done bit is set and reports completion or error to the local controller. It sits between the host-side job queue / scheduler and the operator's axi_ctrl port.

Parameters:
POLL_GAP, 16, idle cycles between consecutive STAT reads (0 = back-to-back).
MAX_POLLS, 32'd1048576, STAT reads before timeout error (0 = never time out).
BASE_ADDR, 0, byte address of register 0 in the slave's space.

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
axi_ctrl  AXI4L.m  AXIL_DATA_BITS data  master port to operator config slave
cmd_valid  in  1  job descriptor valid
cmd_ready  out  1  job accepted when cmd_valid & cmd_ready
cmd_num_clusters  in  NUM_CLUSTER_BITS+1  cluster count
cmd_data_dim  in  MAX_DEPTH_BITS+1  data dimension
cmd_data_set_size  in  64  data set size
cmd_precision  in  8  precision
cmd_select  in  1  mux select
busy  out  1  job in flight
done  out  1  one-cycle pulse: job finished cleanly
error  out  1  sticky; cleared by next accepted cmd
err_code  out  2  0 none, 1 bad bresp, 2 bad rresp, 3 timeout

Behaviour:
- Reset is asynchronous, active-low, and applies to all flops.
- Reset values: all axi valid/ready outputs 0, awaddr/araddr/wdata 0, wstrb 0, cmd_ready 0, busy 0, done 0, error 0, err_code 0. FSM goes to IDLE.
- Register byte offsets are BASE_ADDR + idx*(AXIL_DATA_BITS/8). idx values: CTRL 0, STAT 1, SELECT 2, NUM_CLUSTERS 3, DATA_DIM 4, PRECISION 5, DATA_SET_SIZE 6. With 64-bit data these are 0x00, 0x08, 0x10, 0x18, 0x20, 0x28, 0x30.
- Parameter fields are zero-extended to AXIL_DATA_BITS. wstrb is all ones for every write. awprot/arprot are 0.
- IDLE: cmd_ready=1. On handshake, latch all cmd_* fields, clear error/err_code, set busy=1, go to WR_ADDR with seq=0.
- Write sequence: SELECT, NUM_CLUSTERS, DATA_DIM, PRECISION, DATA_SET_SIZE, then CTRL with wdata=1.
- WR_ADDR: assert awvalid and wvalid in the same cycle, with both driven from registers.
  - Deassert each channel independently on its own ready.
  - Leave only when both channels have handshaken, in either order or the same cycle, then go to WR_RESP.
  - awaddr, wdata and wstrb stay stable while the corresponding valid is high.
- WR_RESP: bready=1.
  - On bvalid with bresp!=0: err_code=1, go to ERR.
  - Otherwise increment seq. Return to WR_ADDR, or go to POLL_RD after the CTRL write.
- Exactly one outstanding transaction at any time; no overlap between transactions.
- POLL_RD: arvalid=1, araddr=STAT. Hold until arready, then go to POLL_DATA.
- POLL_DATA: rready=1. On rvalid:
  - rresp!=0: err_code=2, go to ERR.
  - rdata[0]=1: go to FIN.
  - Otherwise increment the poll counter. If MAX_POLLS!=0 and the count reaches MAX_POLLS: err_code=3, go to ERR. Else go to POLL_WAIT.
- POLL_WAIT: count POLL_GAP cycles, then go to POLL_RD. With POLL_GAP=0, go straight to POLL_RD on the next cycle.
- FIN: done=1 for exactly one cycle, busy=0, go to IDLE.
- ERR: error=1 (sticky), busy=0, done stays 0, go to IDLE. An in-flight AXI response has always completed before ERR is entered.
- Latency: first awvalid appears 1 cycle after the cmd handshake. cmd_ready is low from the handshake cycle+1 until IDLE is re-entered.
- Poll counter width is 32 bits and does not wrap before MAX_POLLS.
- A reset mid-transaction drops valids immediately and discards the job; no recovery of the slave-side state is attempted.

Test Plan:
- Nominal job (clusters=8, dim=16, precision=32, size=0x1_0000_0000, select=1): writes observed in order 0x10=1, 0x18=8, 0x20=16, 0x28=32, 0x30=0x100000000, 0x00=1. The slave model asserts done after 3 polls; done pulses once and error=0.
- Channel skew: the slave accepts AW 4 cycles before W and vice versa. Each write is issued exactly once, with addr/data stable until each ready.
- Slave returns bresp=2 on the DATA_DIM write: no further AW is issued, error=1, err_code=1, done never pulses, cmd_ready=1 afterwards.
- MAX_POLLS=4, STAT never sets done: exactly 4 ARs, with POLL_GAP idle cycles between each. Then err_code=3. A following good cmd clears error and completes.
- rresp=2 on the 2nd STAT read: err_code=2 and no 3rd AR.
- aresetn asserted while awvalid=1 mid-sequence: all valids drop asynchronously to 0. After release the block is IDLE with cmd_ready=1, and the next job runs cleanly.
